counter_wrap_monitor: RTL and testbench

Downstream consumer of the free-running modulo counter. Samples the counter value every cycle and checks that it follows the legal sequence 0, 1, …, TERMINAL, 0. Wrap-arounds and sequence errors are logged as event records in a small FIFO that is drained over a valid/ready interface. Also keeps a live count of completed wraps (epoch).

---
 rtl/counter_wrap_monitor_pkg.sv | 30 +++
 rtl/counter_wrap_monitor_if.sv | 32 +++
 rtl/counter_wrap_monitor_evt_fifo.sv | 62 ++++++
 rtl/counter_wrap_monitor.sv | 110 +++++++++++
 tb/tb_counter_wrap_monitor.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/counter_wrap_monitor_pkg.sv
// ============================================================================
// counter_mon_pkg : shared types for the counter wrap monitor
// Rev 1.0
// ============================================================================
`default_nettype none

package counter_mon_pkg;

  localparam int unsigned COUNT_W_DEF = 4;
  localparam int unsigned EPOCH_W_DEF = 8;

  typedef enum logic {
    EVT_WRAP = 1'b0,
    EVT_ERR  = 1'b1
  } evt_kind_e;

  typedef enum logic {
    SYNC  = 1'b0,
    TRACK = 1'b1
  } mon_state_e;

  typedef struct packed {
    evt_kind_e              kind;
    logic [EPOCH_W_DEF-1:0] epoch;
    logic [COUNT_W_DEF-1:0] count;
  } evt_rec_t;

endpackage

`default_nettype wire

// File: rtl/counter_wrap_monitor_if.sv
// ============================================================================
// counter_wrap_monitor_if : valid/ready event record channel
// Rev 1.0
// ============================================================================
`default_nettype none

interface counter_wrap_monitor_if
  import counter_mon_pkg::*;
#(
  parameter int unsigned COUNT_W = 4,
  parameter int unsigned EPOCH_W = 8
);

  logic               evt_valid;
  logic               evt_ready;
  evt_kind_e          evt_kind;
  logic [EPOCH_W-1:0] evt_epoch;
  logic [COUNT_W-1:0] evt_count;

  modport master (
    output evt_valid, evt_kind, evt_epoch, evt_count,
    input  evt_ready
  );

  modport slave (
    input  evt_valid, evt_kind, evt_epoch, evt_count,
    output evt_ready
  );

endinterface

`default_nettype wire

// File: rtl/counter_wrap_monitor_evt_fifo.sv
// ============================================================================
// evt_fifo : synchronous event-record FIFO, pointer pair with extra wrap bit
// Rev 1.0
// ============================================================================
`default_nettype none

module evt_fifo
  import counter_mon_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type         REC_T = evt_rec_t
) (
  input  wire  clk,
  input  wire  rst,
  input  wire  push_i,
  input  REC_T rec_i,
  output logic full_o,
  input  wire  pop_i,
  output logic empty_o,
  output REC_T head_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  REC_T        mem_q [DEPTH];
  logic        pop_ok;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (push_i) wr_d = wr_q + 1'b1;
    if (pop_ok) rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q[AW-1:0]] <= rec_i;
  end

  // Head reads as zero while empty, so the fields are clean straight out of reset.
  always_comb begin
    head_o = '0;
    if (!empty_o) head_o = mem_q[rd_q[AW-1:0]];
  end

endmodule

`default_nettype wire

// File: rtl/counter_wrap_monitor.sv
// ============================================================================
// counter_wrap_monitor : checks a modulo counter sequence, logs wraps/errors
// Rev 1.0
// ============================================================================
`default_nettype none

module counter_wrap_monitor
  import counter_mon_pkg::*;
#(
  parameter int unsigned COUNT_W  = 4,
  parameter int unsigned TERMINAL = 13,
  parameter int unsigned EPOCH_W  = 8,
  parameter int unsigned DEPTH    = 4
) (
  input  wire                  clk,
  input  wire                  rst,
  input  wire  [COUNT_W-1:0]   count_in,
  output logic [EPOCH_W-1:0]   epoch,
  output logic                 overflow,
  counter_wrap_monitor_if.master evt
);

  typedef struct packed {
    evt_kind_e          kind;
    logic [EPOCH_W-1:0] epoch;
    logic [COUNT_W-1:0] count;
  } rec_t;

  localparam logic [COUNT_W-1:0] TERM_C = COUNT_W'(TERMINAL);

  mon_state_e         state_q, state_d;
  logic [COUNT_W-1:0] prev_q, prev_d, expected;
  logic [EPOCH_W-1:0] epoch_q, epoch_d;
  logic               overflow_q, overflow_d;
  logic               evt_hit, push, pop, fifo_full, fifo_empty;
  rec_t               rec, head;

  assign pop = evt.evt_valid && evt.evt_ready;

  always_comb begin
    state_d  = state_q;
    prev_d   = prev_q;
    epoch_d  = epoch_q;
    evt_hit  = 1'b0;
    rec      = '0;
    expected = (prev_q == TERM_C) ? '0 : prev_q + 1'b1;
    case (state_q)
      SYNC: begin
        prev_d  = count_in;
        state_d = TRACK;
      end
      TRACK: begin
        prev_d = count_in;
        // Out-of-range values on either side are errors even if prev+1 aliases.
        if ((count_in == expected) && (count_in <= TERM_C) && (prev_q <= TERM_C)) begin
          if (prev_q == TERM_C) begin
            epoch_d = epoch_q + 1'b1;
            evt_hit = 1'b1;
            rec     = '{kind: EVT_WRAP, epoch: epoch_d, count: count_in};
          end
        end else begin
          evt_hit = 1'b1;
          rec     = '{kind: EVT_ERR, epoch: epoch_q, count: count_in};
        end
      end
      default: state_d = SYNC;
    endcase
  end

  assign push       = evt_hit && (!fifo_full || pop);
  assign overflow_d = overflow_q || (evt_hit && !push);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= SYNC;
      prev_q     <= '0;
      epoch_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      epoch_q    <= epoch_d;
      overflow_q <= overflow_d;
    end
  end

  evt_fifo #(
    .DEPTH (DEPTH),
    .REC_T (rec_t)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .rec_i   (rec),
    .full_o  (fifo_full),
    .pop_i   (pop),
    .empty_o (fifo_empty),
    .head_o  (head)
  );

  assign evt.evt_valid = !fifo_empty;
  assign evt.evt_kind  = head.kind;
  assign evt.evt_epoch = head.epoch;
  assign evt.evt_count = head.count;
  assign epoch         = epoch_q;
  assign overflow      = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_counter_wrap_monitor.sv
// ============================================================================
// tb_counter_wrap_monitor : directed vector bench for counter_wrap_monitor
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_counter_wrap_monitor;
  import counter_mon_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] count_in = '0;
  logic [7:0] epoch1;
  logic [1:0] epoch2;
  logic       ovf1, ovf2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  counter_wrap_monitor_if #(.COUNT_W(4), .EPOCH_W(8)) ev1 ();
  counter_wrap_monitor_if #(.COUNT_W(4), .EPOCH_W(2)) ev2 ();

  counter_wrap_monitor #(.COUNT_W(4), .TERMINAL(13), .EPOCH_W(8), .DEPTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .count_in (count_in),
    .epoch    (epoch1),
    .overflow (ovf1),
    .evt      (ev1.master)
  );

  counter_wrap_monitor #(.COUNT_W(4), .TERMINAL(13), .EPOCH_W(2), .DEPTH(4)) dut2 (
    .clk      (clk),
    .rst      (rst),
    .count_in (count_in),
    .epoch    (epoch2),
    .overflow (ovf2),
    .evt      (ev2.master)
  );

  typedef struct {
    int c;   int r;
    int v;   int k;   int ep;  int cnt;
    int e;   int o;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input int c, input int r, input int v, input int k,
                     input int ep, input int cnt, input int e, input int o);
    vec_t x;
    x.c = c; x.r = r; x.v = v; x.k = k; x.ep = ep; x.cnt = cnt; x.e = e; x.o = o;
    tbl.push_back(x);
  endtask

  task automatic step(input int c, input logic r);
    count_in      = 4'(c);
    ev1.evt_ready = r;
    ev2.evt_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic run_wrap(input logic r);
    for (int v = 1; v <= 13; v++) step(v, r);
    step(0, r);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #3 rst = 1'b0;
  endtask

  task automatic chk_head(input string name, input int k, input int ep, input int cnt);
    chk({name, "_valid"}, int'(ev1.evt_valid), 1);
    chk({name, "_kind"},  int'(ev1.evt_kind),  k);
    chk({name, "_epoch"}, int'(ev1.evt_epoch), ep);
    chk({name, "_count"}, int'(ev1.evt_count), cnt);
  endtask

  initial begin
    ev1.evt_ready = 1'b0;
    ev2.evt_ready = 1'b0;

    // Reset state
    #2;
    chk("rst_valid", int'(ev1.evt_valid), 0);
    chk("rst_ovf",   int'(ovf1),          0);
    chk("rst_epoch", int'(epoch1),        0);
    chk("rst_count", int'(ev1.evt_count), 0);
    @(posedge clk);
    #3 rst = 1'b0;

    // Vector table: first sample syncs, one wrap, resync after error, out-of-range values
    add(0, 1, 0, 0, 0, 0, 0, 0);
    for (int v = 1; v <= 13; v++) add(v, 1, 0, 0, 0, 0, 0, 0);
    add(0, 1, 1, 0, 1, 0, 1, 0);
    add(1, 1, 0, 0, 0, 0, 1, 0);
    for (int v = 2; v <= 5; v++) add(v, 1, 0, 0, 0, 0, 1, 0);
    add(9,  1, 1, 1, 1, 9,  1, 0);
    add(10, 1, 0, 0, 0, 0,  1, 0);
    for (int v = 11; v <= 13; v++) add(v, 1, 0, 0, 0, 0, 1, 0);
    add(14, 1, 1, 1, 1, 14, 1, 0);
    add(15, 1, 1, 1, 1, 15, 1, 0);
    add(0,  1, 1, 1, 1, 0,  1, 0);
    add(1,  1, 0, 0, 0, 0,  1, 0);

    foreach (tbl[i]) begin
      step(tbl[i].c, 1'(tbl[i].r));
      chk($sformatf("vec%0d_valid", i), int'(ev1.evt_valid), tbl[i].v);
      if (tbl[i].v != 0) begin
        chk($sformatf("vec%0d_kind", i),  int'(ev1.evt_kind),  tbl[i].k);
        chk($sformatf("vec%0d_epoch", i), int'(ev1.evt_epoch), tbl[i].ep);
        chk($sformatf("vec%0d_count", i), int'(ev1.evt_count), tbl[i].cnt);
      end
      chk($sformatf("vec%0d_live_epoch", i), int'(epoch1), tbl[i].e);
      chk($sformatf("vec%0d_ovf", i),        int'(ovf1),   tbl[i].o);
    end

    // Five wraps with no consumer: four stored, fifth dropped
    do_reset();
    step(0, 1'b0);
    for (int w = 1; w <= 4; w++) run_wrap(1'b0);
    chk("fill4_ovf",   int'(ovf1),   0);
    chk("fill4_epoch", int'(epoch1), 4);
    run_wrap(1'b0);
    chk("fill5_ovf",   int'(ovf1),   1);
    chk("fill5_epoch", int'(epoch1), 5);
    for (int k = 1; k <= 4; k++) begin
      chk_head($sformatf("drain%0d", k), 0, k, 0);
      step(k, 1'b1);
    end
    chk("drain_empty", int'(ev1.evt_valid), 0);
    chk("drain_ovf",   int'(ovf1),          1);

    // Full FIFO, wrap coincides with a pop
    do_reset();
    step(0, 1'b0);
    for (int w = 1; w <= 4; w++) run_wrap(1'b0);
    for (int v = 1; v <= 13; v++) step(v, 1'b0);
    step(0, 1'b1);
    chk("fullpop_ovf",   int'(ovf1),   0);
    chk("fullpop_epoch", int'(epoch1), 5);
    chk_head("fullpop_head", 0, 2, 0);
    run_wrap(1'b0);
    chk("fullpop_still_full", int'(ovf1), 1);
    for (int k = 2; k <= 5; k++) begin
      chk_head($sformatf("fpdrain%0d", k), 0, k, 0);
      step(k - 1, 1'b1);
    end
    chk("fpdrain_empty", int'(ev1.evt_valid), 0);

    // Narrow epoch counter wraps modulo 4
    do_reset();
    step(0, 1'b1);
    for (int w = 1; w <= 4; w++) begin
      run_wrap(1'b1);
      chk($sformatf("ep2_live%0d", w),  int'(epoch2),        w % 4);
      chk($sformatf("ep2_valid%0d", w), int'(ev2.evt_valid), 1);
      chk($sformatf("ep2_kind%0d", w),  int'(ev2.evt_kind),  0);
      chk($sformatf("ep2_rec%0d", w),   int'(ev2.evt_epoch), w % 4);
      chk($sformatf("ep2_cnt%0d", w),   int'(ev2.evt_count), 0);
    end
    step(15, 1'b1);
    step(0, 1'b1);
    chk("ep2_err_valid", int'(ev2.evt_valid), 1);
    chk("ep2_err_kind",  int'(ev2.evt_kind),  1);
    chk("ep2_err_epoch", int'(ev2.evt_epoch), 0);
    chk("ep2_err_count", int'(ev2.evt_count), 0);

    // Asynchronous reset mid-cycle with records stored and overflow set
    do_reset();
    step(0, 1'b0);
    for (int w = 1; w <= 5; w++) run_wrap(1'b0);
    step(1, 1'b1);
    ev1.evt_ready = 1'b0;
    ev2.evt_ready = 1'b0;
    chk("pre_rst_valid", int'(ev1.evt_valid), 1);
    chk("pre_rst_ovf",   int'(ovf1),          1);
    #3 rst = 1'b1;
    #1;
    chk("arst_valid", int'(ev1.evt_valid), 0);
    chk("arst_ovf",   int'(ovf1),          0);
    chk("arst_epoch", int'(epoch1),        0);
    chk("arst_count", int'(ev1.evt_count), 0);
    @(posedge clk);
    #3 rst = 1'b0;
    step(7, 1'b1);
    chk("post_sync_valid", int'(ev1.evt_valid), 0);
    step(8, 1'b1);
    chk("post_legal_valid", int'(ev1.evt_valid), 0);
    step(3, 1'b0);
    chk_head("post_err", 1, 0, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
